// File: rtl/sync_dp_ram_be_init.sv
// Simple-dual-port RAM with per-byte write enables, a hardware init fill after reset,
// selectable read-during-write behaviour and an optional extra output register.
module sync_dp_ram_be_init #(
    parameter int         DATA_WIDTH = 64,
    parameter int         ADDR_WIDTH = 8,
    parameter int         DATA_DEPTH = 256,
    parameter int         OUT_REGS   = 0,
    parameter int         READ_MODE  = 0,
    parameter int         INIT_EN    = 1,
    parameter logic [7:0] INIT_BYTE  = 8'h00
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RI,
    output logic                    Ready_SO,
    input  logic                    WrEn_SI,
    input  logic [ADDR_WIDTH-1:0]   WrAddr_DI,
    input  logic [DATA_WIDTH/8-1:0] BEn_SI,
    input  logic [DATA_WIDTH-1:0]   WrData_DI,
    input  logic                    RdEn_SI,
    input  logic [ADDR_WIDTH-1:0]   RdAddr_DI,
    output logic                    RdValid_DO,
    output logic [DATA_WIDTH-1:0]   RdData_DO
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_DEPTH - 1);

    typedef enum logic [1:0] {
        INIT,
        IDLE_RST,
        READY
    } state_t;

    localparam state_t RST_STATE = (INIT_EN != 0) ? INIT : IDLE_RST;

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0] init_cnt;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    logic wr_in_range;
    logic rd_in_range;
    logic ready;
    logic init_we;
    logic wr_ok;
    logic rd_ok;

    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_valid_1;
    logic [DATA_WIDTH-1:0] rd_data_1;

    if (DATA_WIDTH % 8 != 0) begin : g_chk_width
        $error("sync_dp_ram_be_init: DATA_WIDTH must be a multiple of 8");
    end
    if (DATA_DEPTH < 1) begin : g_chk_depth_min
        $error("sync_dp_ram_be_init: DATA_DEPTH must be at least 1");
    end
    if (DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_chk_depth_max
        $error("sync_dp_ram_be_init: DATA_DEPTH exceeds the address space");
    end

    assign wr_idx      = WrAddr_DI[IDX_W-1:0];
    assign rd_idx      = RdAddr_DI[IDX_W-1:0];
    assign wr_in_range = ({1'b0, WrAddr_DI} < DEPTH_C);
    assign rd_in_range = ({1'b0, RdAddr_DI} < DEPTH_C);

    // A reset edge wins over everything, including a pending init write or request.
    assign ready   = (state_q == READY);
    assign init_we = (state_q == INIT) && !Rst_RI;
    assign wr_ok   = ready && WrEn_SI && wr_in_range && !Rst_RI;
    assign rd_ok   = ready && RdEn_SI && !Rst_RI;

    assign Ready_SO = ready;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:     if (init_cnt == LAST_IDX) state_d = READY;
            IDLE_RST: state_d = READY;
            READY:    state_d = READY;
            default:  state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            init_cnt <= '0;
        end else if (state_q == INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // One narrow array per byte lane keeps each lane a plain single-write-port memory.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [7:0] lane_mem [DATA_DEPTH];
        logic [7:0] rd_lane;

        always_ff @(posedge Clk_CI) begin
            if (init_we) begin
                lane_mem[init_cnt] <= INIT_BYTE;
            end else if (wr_ok && BEn_SI[i]) begin
                lane_mem[wr_idx] <= WrData_DI[8*i +: 8];
            end
        end

        always_comb begin
            rd_lane = lane_mem[rd_idx];
            if (READ_MODE != 0 && wr_ok && BEn_SI[i] && (wr_idx == rd_idx)) begin
                rd_lane = WrData_DI[8*i +: 8];
            end
        end

        assign rd_word[8*i +: 8] = rd_in_range ? rd_lane : 8'h00;
    end

    // Data registers only load on an accepted read so the output holds between reads.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            rd_valid_1 <= 1'b0;
            rd_data_1  <= '0;
        end else begin
            rd_valid_1 <= rd_ok;
            if (rd_ok) begin
                rd_data_1 <= rd_word;
            end
        end
    end

    if (OUT_REGS != 0) begin : g_out_reg
        logic                  rd_valid_2;
        logic [DATA_WIDTH-1:0] rd_data_2;

        always_ff @(posedge Clk_CI) begin
            if (Rst_RI) begin
                rd_valid_2 <= 1'b0;
                rd_data_2  <= '0;
            end else begin
                rd_valid_2 <= rd_valid_1;
                if (rd_valid_1) begin
                    rd_data_2 <= rd_data_1;
                end
            end
        end

        assign RdValid_DO = rd_valid_2;
        assign RdData_DO  = rd_data_2;
    end else begin : g_no_out_reg
        assign RdValid_DO = rd_valid_1;
        assign RdData_DO  = rd_data_1;
    end

endmodule
